// File: rtl/uart_pkg.sv
// Shared UART frame constants, frame FSM state type and baud divider helper.
// The multi-byte receiver uses the same constants so both ends agree on framing.
package uart_pkg;

    localparam logic [7:0]  HEAD_BYTE   = 8'h55;
    localparam logic [7:0]  TAIL_BYTE   = 8'hAA;
    localparam int unsigned FRAME_LEN   = 14;
    localparam int unsigned PAYLOAD_LEN = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } frame_state_t;

    // Clocks per serial bit for a given system clock and baud rate.
    function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                            input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_mult_byte_tx_if.sv
// Request/status bundle of the frame transmitter.
// master = requester (control path), slave = transmitter.
interface uart_mult_byte_tx_if;
    import uart_pkg::*;

    logic                       send_req;
    logic [8*PAYLOAD_LEN-1:0]   tx_payload;
    logic                       uart_txd;
    logic                       tx_busy;
    logic                       byte_done;
    logic [3:0]                 byte_idx;
    logic                       pack_done;

    modport master (
        output send_req, tx_payload,
        input  uart_txd, tx_busy, byte_done, byte_idx, pack_done
    );

    modport slave (
        input  send_req, tx_payload,
        output uart_txd, tx_busy, byte_done, byte_idx, pack_done
    );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser: start bit, d0..d7 LSB first, stop bit.
// done is asserted during the last clock of the stop bit so the frame
// controller can react without adding an extra idle cycle on the line.
module uart_byte_tx #(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

    logic [15:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        bit_end;

    assign bit_end = busy && (clk_cnt == BIT_LAST);
    assign done    = bit_end && (bit_cnt == 4'd9);

    // Bit timing and shifting: each of the 10 bit slots lasts BPS_CNT clocks, txd stays registered.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            txd       <= 1'b1;
            busy      <= 1'b0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (!busy) begin
            if (start) begin
                busy      <= 1'b1;
                txd       <= 1'b0;
                clk_cnt   <= '0;
                bit_cnt   <= '0;
                shift_reg <= data;
            end
        end else if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                busy    <= 1'b0;
                bit_cnt <= '0;
                txd     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd8) begin
                    txd <= 1'b1;
                end else begin
                    txd       <= shift_reg[0];
                    shift_reg <= {1'b0, shift_reg[7:1]};
                end
            end
        end else begin
            clk_cnt <= clk_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Frame transmitter: snapshots a 12-byte payload on request and sends
// HEAD, payload[0..11], TAIL as 8N1 bytes with an idle gap between bytes.
module uart_mult_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned UART_BPS  = 115200,
    parameter int unsigned GAP_BITS  = 1,
    parameter logic [7:0]  HEAD_BYTE = uart_pkg::HEAD_BYTE,
    parameter logic [7:0]  TAIL_BYTE = uart_pkg::TAIL_BYTE
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_mult_byte_tx_if.slave tx_if
);

    localparam int unsigned BPS_CNT    = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int unsigned GAP_CYCLES = GAP_BITS * BPS_CNT;
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_IDX   = 4'(FRAME_LEN - 1);

    frame_state_t state, next_state;

    logic [7:0]  snapshot [PAYLOAD_LEN];
    logic [3:0]  byte_idx_r;
    logic [31:0] gap_cnt;
    logic [7:0]  cur_byte;
    logic [3:0]  snap_sel;
    logic        accept;
    logic        gap_end;
    logic        bt_start;
    logic        bt_txd;
    logic        bt_busy;
    logic        bt_done;
    logic        byte_end;

    assign accept   = (state == ST_IDLE) && tx_if.send_req;
    assign gap_end  = (gap_cnt == GAP_LAST);
    assign byte_end = bt_busy && bt_done;
    assign snap_sel = byte_idx_r - 4'd1;

    // Frame state register; reset abandons any partial frame.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; with no gap configured the FSM goes straight from SHIFT to LOAD.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (tx_if.send_req) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (byte_end) begin
                    if (byte_idx_r == LAST_IDX) begin
                        next_state = ST_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        next_state = ST_LOAD;
                    end else begin
                        next_state = ST_GAP;
                    end
                end
            end
            ST_GAP:   if (gap_end) next_state = ST_LOAD;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; busy stays high through DONE so a request there is ignored.
    always_comb begin
        bt_start          = (state == ST_LOAD);
        tx_if.tx_busy     = (state != ST_IDLE);
        tx_if.byte_done   = (state == ST_SHIFT) && byte_end;
        tx_if.pack_done   = (state == ST_DONE);
    end

    // Payload snapshot, taken only in the accept cycle so later payload changes are ignored.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            for (int k = 0; k < PAYLOAD_LEN; k++) begin
                snapshot[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < PAYLOAD_LEN; k++) begin
                snapshot[k] <= tx_if.tx_payload[8*k +: 8];
            end
        end
    end

    // Byte index: advances after each non-tail byte, cleared on accept and at frame end.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            byte_idx_r <= '0;
        end else if (accept || state == ST_DONE) begin
            byte_idx_r <= '0;
        end else if (state == ST_SHIFT && byte_end && byte_idx_r != LAST_IDX) begin
            byte_idx_r <= byte_idx_r + 4'd1;
        end
    end

    // Inter-byte gap counter, only running while in GAP.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP && !gap_end) begin
            gap_cnt <= gap_cnt + 32'd1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Byte selection: header, snapshot byte idx-1, or tail.
    always_comb begin
        cur_byte = HEAD_BYTE;
        if (byte_idx_r == LAST_IDX) begin
            cur_byte = TAIL_BYTE;
        end else if (byte_idx_r != 4'd0) begin
            cur_byte = snapshot[snap_sel];
        end
    end

    assign tx_if.byte_idx = byte_idx_r;
    assign tx_if.uart_txd = bt_txd;

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (bt_start),
        .data      (cur_byte),
        .txd       (bt_txd),
        .busy      (bt_busy),
        .done      (bt_done)
    );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Self-checking bench for uart_mult_byte_tx: two instances (one bit-period gap
// and no gap) checked cycle by cycle against a waveform built from the framing
// rules, plus a line decoder acting as the receiving end.
module tb_uart_mult_byte_tx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned UART_BPS = 125_000;
    localparam int          B        = 8;

    logic sys_clk;
    logic sys_rst_n;

    int compare_count = 0;
    int fail_count    = 0;

    uart_mult_byte_tx_if if_a ();
    uart_mult_byte_tx_if if_b ();

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .GAP_BITS (1)
    ) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_if     (if_a.slave)
    );

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .GAP_BITS (0)
    ) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_if     (if_b.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input int sel, input logic req, input logic [95:0] pl);
        if (sel == 0) begin
            if_a.send_req   = req;
            if_a.tx_payload = pl;
        end else begin
            if_b.send_req   = req;
            if_b.tx_payload = pl;
        end
    endtask

    task automatic readOutputs(input int sel, output logic txd, output logic busy,
                               output logic bd, output logic pd, output logic [3:0] idx);
        if (sel == 0) begin
            txd = if_a.uart_txd; busy = if_a.tx_busy; bd = if_a.byte_done;
            pd = if_a.pack_done; idx = if_a.byte_idx;
        end else begin
            txd = if_b.uart_txd; busy = if_b.tx_busy; bd = if_b.byte_done;
            pd = if_b.pack_done; idx = if_b.byte_idx;
        end
    endtask

    function automatic logic [7:0] frameByte(input logic [95:0] pl, input int k);
        if (k == 0) return 8'h55;
        if (k == 13) return 8'hAA;
        return pl[8*(k-1) +: 8];
    endfunction

    function automatic logic [95:0] randPayload();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Sends one frame on the selected instance and checks it against the expected waveform.
    task automatic applyStimulus(input int sel, input logic [95:0] payload, input bit disturb);
        int gap_cyc = (sel == 0) ? B : 0;
        bit exp_txd[$]; bit exp_busy[$]; bit exp_bd[$]; bit exp_pd[$]; int exp_idx[$];
        bit obs_txd[$];
        int txd_err = 0, busy_err = 0, bd_err = 0, pd_err = 0, idx_err = 0;
        int bd_cnt = 0, pd_cnt = 0;
        int pos, nbytes, prev_end, gap_err;
        logic txd, busy, bd, pd;
        logic [3:0] idx;
        logic [95:0] drive_pl;
        logic [8:0] dec;
        logic [9:0] bits;

        // expected per-cycle waveform, starting with the LOAD cycle after accept
        exp_txd.push_back(1); exp_busy.push_back(1); exp_bd.push_back(0);
        exp_pd.push_back(0); exp_idx.push_back(0);
        for (int k = 0; k < 14; k++) begin
            bits = {1'b1, frameByte(payload, k), 1'b0};
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < B; c++) begin
                    exp_txd.push_back(bits[j]); exp_busy.push_back(1);
                    exp_bd.push_back(j == 9 && c == B - 1);
                    exp_pd.push_back(0); exp_idx.push_back(k);
                end
            end
            if (k < 13) begin
                for (int c = 0; c <= gap_cyc; c++) begin
                    exp_txd.push_back(1); exp_busy.push_back(1); exp_bd.push_back(0);
                    exp_pd.push_back(0); exp_idx.push_back(k + 1);
                end
            end
        end
        exp_txd.push_back(1); exp_busy.push_back(1); exp_bd.push_back(0);
        exp_pd.push_back(1); exp_idx.push_back(13);
        for (int c = 0; c < 2; c++) begin
            exp_txd.push_back(1); exp_busy.push_back(0); exp_bd.push_back(0);
            exp_pd.push_back(0); exp_idx.push_back(0);
        end

        driveReq(sel, 1'b1, payload);
        @(posedge sys_clk); #1;
        drive_pl = disturb ? randPayload() : payload;
        driveReq(sel, 1'b0, drive_pl);

        for (int i = 0; i < exp_txd.size(); i++) begin
            readOutputs(sel, txd, busy, bd, pd, idx);
            driveReq(sel, 1'b0, drive_pl);
            obs_txd.push_back(txd === 1'b1);
            if (txd !== exp_txd[i]) txd_err++;
            if (busy !== exp_busy[i]) busy_err++;
            if (bd !== exp_bd[i]) bd_err++;
            if (pd !== exp_pd[i]) pd_err++;
            if (idx !== 4'(exp_idx[i])) idx_err++;
            if (bd === 1'b1) bd_cnt++;
            if (pd === 1'b1) pd_cnt++;
            if (disturb && ((i % 100) == 50 || i == exp_txd.size() - 3)) begin
                drive_pl = randPayload();
                driveReq(sel, 1'b1, drive_pl);
            end
            @(posedge sys_clk); #1;
        end
        driveReq(sel, 1'b0, drive_pl);

        checkOutput("txd_wave_err", txd_err, 0);
        checkOutput("busy_wave_err", busy_err, 0);
        checkOutput("byte_done_wave_err", bd_err, 0);
        checkOutput("pack_done_wave_err", pd_err, 0);
        checkOutput("byte_idx_wave_err", idx_err, 0);
        checkOutput("byte_done_count", bd_cnt, 14);
        checkOutput("pack_done_count", pd_cnt, 1);

        // decode the captured line as a receiver would, sampling mid-bit
        pos = 0; nbytes = 0; prev_end = -1; gap_err = 0;
        while (nbytes < 14) begin
            while (pos < obs_txd.size() && obs_txd[pos] == 1'b1) pos++;
            if (pos + 9*B + B/2 >= obs_txd.size()) break;
            if (prev_end >= 0 && (pos - prev_end) != gap_cyc + 1) gap_err++;
            for (int j = 0; j < 9; j++) dec[j] = obs_txd[pos + (j+1)*B + B/2];
            checkOutput($sformatf("rx_byte%0d", nbytes), dec, {1'b1, frameByte(payload, nbytes)});
            prev_end = pos + 10*B;
            pos = prev_end;
            nbytes++;
        end
        checkOutput("rx_byte_count", nbytes, 14);
        checkOutput("rx_gap_len_err", gap_err, 0);
    endtask

    task automatic checkIdle(input string tag, input int sel);
        logic txd, busy, bd, pd;
        logic [3:0] idx;
        readOutputs(sel, txd, busy, bd, pd, idx);
        checkOutput({tag, "_txd"}, txd, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_byte_done"}, bd, 0);
        checkOutput({tag, "_pack_done"}, pd, 0);
        checkOutput({tag, "_byte_idx"}, idx, 0);
    endtask

    initial begin
        logic [95:0] pl;
        logic txd, busy, bd, pd;
        logic [3:0] idx;
        bit found;

        sys_rst_n = 1'b1;
        driveReq(0, 1'b0, '0);
        driveReq(1, 1'b0, '0);
        repeat (3) @(posedge sys_clk);
        #1;
        checkIdle("reset_a", 0);
        checkIdle("reset_b", 1);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;

        $display("[TB] incrementing payload, one-bit gap");
        for (int k = 0; k < 12; k++) pl[8*k +: 8] = 8'(k + 1);
        applyStimulus(0, pl, 0);

        $display("[TB] constant 0xA5 payload");
        applyStimulus(0, {12{8'hA5}}, 0);

        $display("[TB] requests and payload changes during a frame");
        applyStimulus(0, randPayload(), 1);
        checkIdle("after_disturb", 0);

        for (int n = 0; n < 2; n++) applyStimulus(0, randPayload(), 0);

        $display("[TB] no-gap instance, all 0xFF payload");
        applyStimulus(1, {12{8'hFF}}, 0);
        applyStimulus(1, randPayload(), 0);

        $display("[TB] reset in the middle of byte 6");
        pl = randPayload();
        driveReq(0, 1'b1, pl);
        @(posedge sys_clk); #1;
        driveReq(0, 1'b0, pl);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            readOutputs(0, txd, busy, bd, pd, idx);
            if (idx == 4'd6 && txd == 1'b0) found = 1;
            else begin
                @(posedge sys_clk); #1;
            end
        end
        checkOutput("wait_byte6_start", found, 1);
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b1;
        #1;
        readOutputs(0, txd, busy, bd, pd, idx);
        checkOutput("midframe_rst_txd", txd, 1);
        checkOutput("midframe_rst_busy", busy, 0);
        checkOutput("midframe_rst_idx", idx, 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checkIdle("after_rst_release", 0);
        applyStimulus(0, randPayload(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
